// File: rtl/class_collector_pkg.sv
// Shared types and helpers for the classifier output path.
// Used by the compute unit and by class_collector.
package class_collector_pkg;

  localparam int CC_NUM_CLASSES = 10;
  localparam int CC_IDX_W = $clog2(CC_NUM_CLASSES);
  localparam int CC_MAX_CLASSES = 64;

  typedef struct packed {
    logic [CC_NUM_CLASSES-1:0] vec;
    logic [CC_IDX_W-1:0]       idx;
    logic                      none;
    logic                      multi;
  } rec_t;

  // Scans from the top down so the lowest set bit wins.
  function automatic logic [5:0] lowest_set(
    input logic [CC_MAX_CLASSES-1:0] v
  );
    logic [5:0] r;
    r = '0;
    for (int i = CC_MAX_CLASSES-1; i >= 0; i--)
      if (v[i]) r = 6'(i);
    return r;
  endfunction

  function automatic logic multi_set(
    input logic [CC_MAX_CLASSES-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < CC_MAX_CLASSES; i++)
      n += int'(v[i]);
    return n >= 2;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular record buffer with a registered head entry.
// Caller never pushes when full unless it also pops.
module result_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  rec_t din,
  output rec_t head,
  output logic empty,
  output logic full
);

  localparam int PW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/class_collector.sv
// Gathers per-neuron class bits into records and queues them
// for a downstream consumer.
module class_collector
  import class_collector_pkg::*;
#(
  parameter int NUM_CLASSES = CC_NUM_CLASSES,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           img_start,
  input  logic                           bit_valid,
  input  logic                           bin_class,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NUM_CLASSES-1:0]         res_vec,
  output logic [$clog2(NUM_CLASSES)-1:0] res_idx,
  output logic                           res_none,
  output logic                           res_multi,
  output logic                           busy,
  output logic                           overflow,
  output logic [15:0]                    img_count
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES-1);

  typedef struct packed {
    logic [NUM_CLASSES-1:0] vec;
    logic [IDX_W-1:0]       idx;
    logic                   none;
    logic                   multi;
  } rec_n_t;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                    state, state_n;
  logic [NUM_CLASSES-1:0]    vec, vec_n, cur_vec;
  logic [IDX_W-1:0]          bit_cnt, bit_cnt_n, cnt_base;
  logic [CC_MAX_CLASSES-1:0] ext;
  logic                      last, push, pop, push_ok;
  logic                      empty, full;
  rec_n_t                    rec, head;

  // img_start wipes the partial image before the current bit lands.
  always_comb begin
    cur_vec  = img_start ? '0 : vec;
    cnt_base = img_start ? '0 : bit_cnt;
    if (bit_valid) cur_vec[cnt_base] = bin_class;
    last      = bit_valid && (cnt_base == LAST_IDX);
    state_n   = state;
    vec_n     = vec;
    bit_cnt_n = bit_cnt;
    if (last) begin
      state_n   = IDLE;
      vec_n     = '0;
      bit_cnt_n = '0;
    end else if (bit_valid) begin
      state_n   = COLLECT;
      vec_n     = cur_vec;
      bit_cnt_n = cnt_base + 1'b1;
    end else if (img_start) begin
      state_n   = IDLE;
      vec_n     = '0;
      bit_cnt_n = '0;
    end
  end

  always_comb begin
    ext       = CC_MAX_CLASSES'(cur_vec);
    rec.vec   = cur_vec;
    rec.idx   = IDX_W'(lowest_set(ext));
    rec.none  = ~|cur_vec;
    rec.multi = multi_set(ext);
  end

  assign push    = last;
  assign pop     = ~empty & res_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      bit_cnt   <= '0;
      overflow  <= 1'b0;
      img_count <= '0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      bit_cnt <= bit_cnt_n;
      if (push & ~push_ok) overflow <= 1'b1;
      if (push_ok) img_count <= img_count + 16'd1;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_n_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (rec),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  assign res_valid = ~empty;
  assign res_vec   = empty ? '0 : head.vec;
  assign res_idx   = empty ? '0 : head.idx;
  assign res_none  = ~empty & head.none;
  assign res_multi = ~empty & head.multi;
  assign busy      = (state == COLLECT);

endmodule

// File: tb/tb_class_collector.sv
// Randomised and directed bench for class_collector against a
// queue-based reference model.
module tb_class_collector;

  localparam int NC    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          img_start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bin_class = 1'b0;
  logic          res_ready = 1'b0;
  logic          res_valid;
  logic [NC-1:0] res_vec;
  logic [3:0]    res_idx;
  logic          res_none;
  logic          res_multi;
  logic          busy;
  logic          overflow;
  logic [15:0]   img_count;

  class_collector #(
    .NUM_CLASSES (NC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .img_start (img_start),
    .bit_valid (bit_valid),
    .bin_class (bin_class),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_vec   (res_vec),
    .res_idx   (res_idx),
    .res_none  (res_none),
    .res_multi (res_multi),
    .busy      (busy),
    .overflow  (overflow),
    .img_count (img_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [NC-1:0] m_q[$];
  logic [NC-1:0] m_vec;
  int            m_cnt;
  logic          m_over;
  logic [15:0]   m_count;
  logic [NC-1:0] imgs [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic          pop;
    logic          push;
    logic [NC-1:0] rec;
    push = 1'b0;
    rec  = '0;
    if (rst) begin
      m_q.delete();
      m_vec   = '0;
      m_cnt   = 0;
      m_over  = 1'b0;
      m_count = '0;
    end else begin
      pop = (m_q.size() > 0) && res_ready;
      if (img_start) begin
        m_vec = '0;
        m_cnt = 0;
      end
      if (bit_valid) begin
        m_vec[m_cnt] = bin_class;
        m_cnt++;
        if (m_cnt == NC) begin
          push  = 1'b1;
          rec   = m_vec;
          m_vec = '0;
          m_cnt = 0;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(rec);
          m_count++;
        end else begin
          m_over = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_valid", 32'(res_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("m_vec", 32'(res_vec), 32'(m_q[0]));
        chk("m_idx", 32'(res_idx), 32'(m_idx(m_q[0])));
        chk("m_none", 32'(res_none), 32'(m_q[0] == '0));
        chk("m_multi", 32'(res_multi), 32'($countones(m_q[0]) >= 2));
      end
      chk("m_busy", 32'(busy), 32'(m_cnt > 0));
      chk("m_overflow", 32'(overflow), 32'(m_over));
      chk("m_count", 32'(img_count), 32'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [NC-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bin_class = v[i];
      step();
    end
    bit_valid = 1'b0;
    bin_class = 1'b0;
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pct;
    step();
    step();
    rst = 1'b0;
    step();
    cmp_en = 1'b1;

    rst = 1'b1;
    bit_valid = 1'b1;
    bin_class = 1'b1;
    step();
    bit_valid = 1'b0;
    step();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_vec", 32'(res_vec), 32'd0);
    chk("rst_idx", 32'(res_idx), 32'd0);
    chk("rst_none", 32'(res_none), 32'd0);
    chk("rst_multi", 32'(res_multi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", 32'(img_count), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_valid", 32'(res_valid), 32'd0);

    send_bits(10'h008, NC);
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_vec", 32'(res_vec), 32'h008);
    chk("single_idx", 32'(res_idx), 32'd3);
    chk("single_none", 32'(res_none), 32'd0);
    chk("single_multi", 32'(res_multi), 32'd0);
    chk("single_count", 32'(img_count), 32'd1);
    pop_one();
    chk("single_popped", 32'(res_valid), 32'd0);

    send_bits(10'h000, NC);
    chk("zero_none", 32'(res_none), 32'd1);
    chk("zero_idx", 32'(res_idx), 32'd0);
    pop_one();
    send_bits(10'h084, NC);
    chk("two_idx", 32'(res_idx), 32'd2);
    chk("two_multi", 32'(res_multi), 32'd1);
    chk("two_none", 32'(res_none), 32'd0);
    pop_one();

    do_reset();
    for (int k = 0; k < 5; k++) begin
      imgs[k] = NC'($urandom);
      send_bits(imgs[k], NC);
    end
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_count", 32'(img_count), 32'd4);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_order", 32'(res_vec), 32'(imgs[k]));
      step();
    end
    res_ready = 1'b0;
    chk("bp_drained", 32'(res_valid), 32'd0);

    do_reset();
    send_bits(10'h3FF, 6);
    img_start = 1'b1;
    step();
    img_start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    send_bits(10'h200, NC);
    chk("abort_valid", 32'(res_valid), 32'd1);
    chk("abort_vec", 32'(res_vec), 32'h200);
    chk("abort_idx", 32'(res_idx), 32'd9);
    chk("abort_count", 32'(img_count), 32'd1);
    pop_one();
    chk("abort_one", 32'(res_valid), 32'd0);
    send_bits(10'h000, 3);
    img_start = 1'b1;
    bit_valid = 1'b1;
    bin_class = 1'b1;
    step();
    img_start = 1'b0;
    send_bits(10'h000, NC-1);
    chk("coinc_vec", 32'(res_vec), 32'h001);
    chk("coinc_idx", 32'(res_idx), 32'd0);
    chk("coinc_count", 32'(img_count), 32'd2);
    pop_one();

    do_reset();
    for (int k = 0; k < 4; k++) begin
      imgs[k] = NC'($urandom);
      send_bits(imgs[k], NC);
    end
    imgs[4] = NC'($urandom);
    send_bits(imgs[4], NC-1);
    bit_valid = 1'b1;
    bin_class = imgs[4][NC-1];
    res_ready = 1'b1;
    step();
    bit_valid = 1'b0;
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_count", 32'(img_count), 32'd5);
    for (int k = 1; k < 5; k++) begin
      chk("full_order", 32'(res_vec), 32'(imgs[k]));
      step();
    end
    res_ready = 1'b0;
    chk("full_drained", 32'(res_valid), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      pct = ((n / 500) % 2 == 0) ? 15 : 80;
      rst       = ($urandom_range(0, 699) == 0);
      img_start = ($urandom_range(0, 39) == 0);
      bit_valid = ($urandom_range(0, 9) < 7);
      bin_class = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 99) < pct);
      step();
    end
    rst       = 1'b0;
    img_start = 1'b0;
    bit_valid = 1'b0;
    res_ready = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
